// File: rtl/traffic_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// traffic_pkg : light encodings, fault codes and monitor FSM state (rev 1.0)
// ----------------------------------------------------------------------------
package traffic_pkg;

  localparam logic [1:0] c_green   = 2'b00;
  localparam logic [1:0] c_yellow  = 2'b01;
  localparam logic [1:0] c_red     = 2'b10;
  localparam logic [1:0] c_illegal = 2'b11;

  localparam logic [2:0] c_fc_none     = 3'd0;
  localparam logic [2:0] c_fc_illegal  = 3'd1;
  localparam logic [2:0] c_fc_conflict = 3'd2;
  localparam logic [2:0] c_fc_sequence = 3'd3;
  localparam logic [2:0] c_fc_yellow   = 3'd4;
  localparam logic [2:0] c_fc_allred   = 3'd5;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } mon_state_e;

  // Holding a code is always legal; otherwise only G->Y, Y->R, R->G.
  function automatic logic legal_step(input logic [1:0] from_code,
                                      input logic [1:0] to_code);
    logic ok;
    ok = (from_code == to_code);
    case (from_code)
      c_green:  ok = ok || (to_code == c_yellow);
      c_yellow: ok = ok || (to_code == c_red);
      c_red:    ok = ok || (to_code == c_green);
      default:  ok = ok;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_signal_monitor_road.sv
`default_nettype none
// ----------------------------------------------------------------------------
// road_seq_check : per-road transition and yellow dwell checker (rev 1.0)
// ----------------------------------------------------------------------------
module road_seq_check
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW = 3,
  parameter int CW         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cnt_en,
  input  logic [1:0] prev,
  input  logic [1:0] cur,
  output logic       seq_err,
  output logic       yellow_err
);

  localparam logic [CW-1:0] c_min_yellow = CW'(MIN_YELLOW);

  // Count of consecutive YELLOW samples ending at the sample now held in prev.
  logic [CW-1:0] yel_cnt_q;
  logic [CW-1:0] yel_cnt_d;

  always_comb begin
    yel_cnt_d = yel_cnt_q;
    if (cnt_en) begin
      if (cur == c_yellow) begin
        if (yel_cnt_q != {CW{1'b1}}) yel_cnt_d = yel_cnt_q + CW'(1);
      end else begin
        yel_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) yel_cnt_q <= '0;
    else        yel_cnt_q <= yel_cnt_d;
  end

  assign seq_err    = !legal_step(prev, cur);
  assign yellow_err = (prev == c_yellow) && (cur != c_yellow) &&
                      (yel_cnt_q < c_min_yellow);

endmodule
`default_nettype wire

// File: rtl/traffic_signal_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// traffic_signal_monitor : passive light-sequence conflict monitor (rev 1.0)
// ----------------------------------------------------------------------------
module traffic_signal_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW = 3,
  parameter int MIN_ALLRED = 2,
  parameter int FLASH_HALF = 4,
  parameter int CW         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] hwy,
  input  logic [1:0] country,
  input  logic       clear,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash,
  output logic [7:0] phase_cnt
);

  localparam int            FW           = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [FW-1:0] c_flash_last = FW'(FLASH_HALF - 1);
  localparam logic [CW-1:0] c_min_allred = CW'(MIN_ALLRED);

  logic [1:0]    cur_hwy_q, cur_hwy_d, cur_cty_q, cur_cty_d;
  logic [1:0]    prev_hwy_q, prev_hwy_d, prev_cty_q, prev_cty_d;
  logic          cur_vld_q, cur_vld_d;
  logic [CW-1:0] allred_q, allred_d;
  mon_state_e    state_q, state_d;
  logic [2:0]    fault_code_q, fault_code_d;
  logic          flash_q, flash_d;
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  logic [7:0]    phase_cnt_q, phase_cnt_d;

  logic hwy_seq_err, hwy_yel_err, cty_seq_err, cty_yel_err;
  logic allred_err;
  logic [2:0] safety_code, run_code;

  road_seq_check #(.MIN_YELLOW(MIN_YELLOW), .CW(CW)) u_hwy_check (
    .clk(clk), .reset(reset), .cnt_en(cur_vld_q),
    .prev(prev_hwy_q), .cur(cur_hwy_q),
    .seq_err(hwy_seq_err), .yellow_err(hwy_yel_err)
  );

  road_seq_check #(.MIN_YELLOW(MIN_YELLOW), .CW(CW)) u_cty_check (
    .clk(clk), .reset(reset), .cnt_en(cur_vld_q),
    .prev(prev_cty_q), .cur(cur_cty_q),
    .seq_err(cty_seq_err), .yellow_err(cty_yel_err)
  );

  // Sample pipeline and all-red dwell counter; counters ignore the reset-time sample value.
  always_comb begin
    cur_hwy_d  = hwy;
    cur_cty_d  = country;
    prev_hwy_d = cur_hwy_q;
    prev_cty_d = cur_cty_q;
    cur_vld_d  = 1'b1;
    allred_d   = allred_q;
    if (cur_vld_q) begin
      if ((cur_hwy_q == c_red) && (cur_cty_q == c_red)) begin
        if (allred_q != {CW{1'b1}}) allred_d = allred_q + CW'(1);
      end else begin
        allred_d = '0;
      end
    end
  end

  always_comb begin
    allred_err = (((prev_hwy_q != c_green) && (cur_hwy_q == c_green)) ||
                  ((prev_cty_q != c_green) && (cur_cty_q == c_green))) &&
                 (allred_q < c_min_allred);

    safety_code = c_fc_none;
    if ((cur_hwy_q == c_illegal) || (cur_cty_q == c_illegal))
      safety_code = c_fc_illegal;
    else if ((cur_hwy_q != c_red) && (cur_cty_q != c_red))
      safety_code = c_fc_conflict;

    run_code = safety_code;
    if (safety_code == c_fc_none) begin
      if (hwy_seq_err || cty_seq_err)      run_code = c_fc_sequence;
      else if (hwy_yel_err || cty_yel_err) run_code = c_fc_yellow;
      else if (allred_err)                 run_code = c_fc_allred;
    end
  end

  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    flash_d      = flash_q;
    flash_cnt_d  = flash_cnt_q;
    phase_cnt_d  = phase_cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cur_vld_q) begin
          if (safety_code != c_fc_none) begin
            state_d      = ST_FAULT;
            fault_code_d = safety_code;
            flash_d      = 1'b1;
            flash_cnt_d  = '0;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // A country Y->R marks one completed cycle, even if the same sample faults.
        if ((prev_cty_q == c_yellow) && (cur_cty_q == c_red))
          phase_cnt_d = phase_cnt_q + 8'd1;
        if (run_code != c_fc_none) begin
          state_d      = ST_FAULT;
          fault_code_d = run_code;
          flash_d      = 1'b1;
          flash_cnt_d  = '0;
        end
      end
      ST_FAULT: begin
        if (clear) begin
          // A conflict already present when clear lands keeps the fault with its new code.
          if (safety_code != c_fc_none) begin
            fault_code_d = safety_code;
            flash_d      = 1'b1;
            flash_cnt_d  = '0;
          end else begin
            state_d      = ST_INIT;
            fault_code_d = c_fc_none;
            flash_d      = 1'b0;
            flash_cnt_d  = '0;
          end
        end else if (flash_cnt_q == c_flash_last) begin
          flash_d     = ~flash_q;
          flash_cnt_d = '0;
        end else begin
          flash_cnt_d = flash_cnt_q + FW'(1);
        end
      end
      default: begin
        state_d      = ST_INIT;
        fault_code_d = c_fc_none;
        flash_d      = 1'b0;
        flash_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_hwy_q    <= c_red;
      cur_cty_q    <= c_red;
      prev_hwy_q   <= c_red;
      prev_cty_q   <= c_red;
      cur_vld_q    <= 1'b0;
      allred_q     <= '0;
      state_q      <= ST_INIT;
      fault_code_q <= c_fc_none;
      flash_q      <= 1'b0;
      flash_cnt_q  <= '0;
      phase_cnt_q  <= 8'd0;
    end else begin
      cur_hwy_q    <= cur_hwy_d;
      cur_cty_q    <= cur_cty_d;
      prev_hwy_q   <= prev_hwy_d;
      prev_cty_q   <= prev_cty_d;
      cur_vld_q    <= cur_vld_d;
      allred_q     <= allred_d;
      state_q      <= state_d;
      fault_code_q <= fault_code_d;
      flash_q      <= flash_d;
      flash_cnt_q  <= flash_cnt_d;
      phase_cnt_q  <= phase_cnt_d;
    end
  end

  assign fault      = (state_q == ST_FAULT);
  assign fault_code = fault_code_q;
  assign flash      = flash_q;
  assign phase_cnt  = phase_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_signal_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_traffic_signal_monitor : directed + random bench with history-based model
// ----------------------------------------------------------------------------
module tb_traffic_signal_monitor;

  localparam int MIN_YELLOW = 3;
  localparam int MIN_ALLRED = 2;
  localparam int FLASH_HALF = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] hwy = 2'b10;
  logic [1:0] country = 2'b10;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash;
  logic [7:0] phase_cnt;

  int checks = 0;
  int errors = 0;

  traffic_signal_monitor #(
    .MIN_YELLOW(MIN_YELLOW), .MIN_ALLRED(MIN_ALLRED),
    .FLASH_HALF(FLASH_HALF), .CW(8)
  ) dut (
    .clk(clk), .reset(reset), .hwy(hwy), .country(country), .clear(clear),
    .fault(fault), .fault_code(fault_code), .flash(flash), .phase_cnt(phase_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: full sample history since reset; light codes 0=G 1=Y 2=R 3=bad.
  int hs[$];
  int cs[$];
  int m_mode;   // 0 = init, 1 = run, 2 = fault
  int m_code;
  int m_age;    // cycles spent in the current fault
  int m_phase;

  function automatic int yellow_run(input int road, input int idx);
    int n = 0;
    for (int k = idx; k >= 0; k--) begin
      if (((road == 0) ? hs[k] : cs[k]) != 1) break;
      n++;
    end
    return (n > 255) ? 255 : n;
  endfunction

  function automatic int allred_run(input int idx);
    int n = 0;
    for (int k = idx; k >= 0; k--) begin
      if (hs[k] != 2 || cs[k] != 2) break;
      n++;
    end
    return (n > 255) ? 255 : n;
  endfunction

  function automatic bit step_ok(input int a, input int b);
    return (a == b) || (a < 3 && b == (a + 1) % 3);
  endfunction

  function automatic int safety(input int h, input int c);
    if (h == 3 || c == 3) return 1;
    if (h != 2 && c != 2) return 2;
    return 0;
  endfunction

  function automatic int full_check(input int ph, input int pc, input int h, input int c,
                                    input int pidx);
    int s;
    s = safety(h, c);
    if (s != 0) return s;
    if (!step_ok(ph, h) || !step_ok(pc, c)) return 3;
    if ((ph == 1 && h != 1 && yellow_run(0, pidx) < MIN_YELLOW) ||
        (pc == 1 && c != 1 && yellow_run(1, pidx) < MIN_YELLOW)) return 4;
    if (((ph != 0 && h == 0) || (pc != 0 && c == 0)) && allred_run(pidx) < MIN_ALLRED)
      return 5;
    return 0;
  endfunction

  function automatic void enter_fault(input int code);
    m_mode = 2;
    m_code = code;
    m_age  = 0;
  endfunction

  function automatic void model_edge(input int h, input int c, input bit clr);
    int n;
    int code;
    n = hs.size();
    case (m_mode)
      0: if (n > 0) begin
        code = safety(hs[n-1], cs[n-1]);
        if (code != 0) enter_fault(code);
        else m_mode = 1;
      end
      1: begin
        if (cs[n-2] == 1 && cs[n-1] == 2) m_phase = (m_phase + 1) % 256;
        code = full_check(hs[n-2], cs[n-2], hs[n-1], cs[n-1], n - 2);
        if (code != 0) enter_fault(code);
      end
      default: if (clr) begin
        code = safety(hs[n-1], cs[n-1]);
        if (code != 0) enter_fault(code);
        else begin
          m_mode = 0;
          m_code = 0;
        end
      end else begin
        m_age++;
      end
    endcase
    hs.push_back(h);
    cs.push_back(c);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("fault", {31'd0, fault}, (m_mode == 2) ? 1 : 0);
    chk("fault_code", {29'd0, fault_code}, m_code);
    chk("flash", {31'd0, flash}, (m_mode == 2 && (m_age / FLASH_HALF) % 2 == 0) ? 1 : 0);
    chk("phase_cnt", {24'd0, phase_cnt}, m_phase);
  endtask

  // Called just after a falling edge; drives one sample and checks the result.
  task automatic tick(input int h, input int c, input bit clr = 1'b0);
    hwy     = 2'(h);
    country = 2'(c);
    clear   = clr;
    @(posedge clk);
    model_edge(h, c, clr);
    @(negedge clk);
    check_all();
  endtask

  // Asserts reset between clock edges so the clear-down is seen asynchronously.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_fault", {31'd0, fault}, 0);
    chk("rst_code", {29'd0, fault_code}, 0);
    chk("rst_flash", {31'd0, flash}, 0);
    chk("rst_phase", {24'd0, phase_cnt}, 0);
    hs.delete();
    cs.delete();
    m_mode  = 0;
    m_code  = 0;
    m_age   = 0;
    m_phase = 0;
    clear   = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic legal_cycle(input int g, input int y, input int r);
    repeat (g) tick(0, 2);
    repeat (y) tick(1, 2);
    repeat (r) tick(2, 2);
    repeat (g) tick(2, 0);
    repeat (y) tick(2, 1);
    repeat (r) tick(2, 2);
  endtask

  int rh, rc, sel;

  initial begin
    @(negedge clk);
    do_reset();

    // Ten legal cycles with minimum dwells
    repeat (10) legal_cycle(2, MIN_YELLOW, MIN_ALLRED);
    chk("ten_cycles_phase", {24'd0, phase_cnt}, 10);
    chk("ten_cycles_fault", {31'd0, fault}, 0);

    // Both green, then flash cadence, clear, and clear coincident with a conflict
    do_reset();
    tick(0, 2); tick(0, 2);
    tick(0, 0);
    tick(2, 2);
    chk("conflict_code", {29'd0, fault_code}, 2);
    repeat (16) tick(2, 2);
    tick(1, 2, 1'b1);
    chk("clear_fault", {31'd0, fault}, 0);
    tick(1, 2); tick(1, 2); tick(2, 2); tick(2, 2); tick(2, 0); tick(2, 0);
    chk("after_clear_ok", {31'd0, fault}, 0);
    tick(2, 3); tick(2, 2);
    chk("illegal_code", {29'd0, fault_code}, 1);
    tick(0, 0);
    tick(0, 0, 1'b1);
    chk("clear_vs_conflict", {29'd0, fault_code}, 2);
    tick(2, 2); tick(2, 2);

    // Green straight to red
    do_reset();
    tick(0, 2); tick(0, 2); tick(0, 2); tick(2, 2); tick(2, 2);
    chk("bad_transition", {29'd0, fault_code}, 3);

    // Country yellow held one cycle
    do_reset();
    tick(0, 2); tick(0, 2);
    repeat (3) tick(1, 2);
    tick(2, 2); tick(2, 2); tick(2, 0); tick(2, 0); tick(2, 1); tick(2, 2); tick(2, 2);
    chk("short_yellow", {29'd0, fault_code}, 4);

    // Short all-red, then the same with an illegal highway code
    do_reset();
    tick(0, 2); tick(0, 2);
    repeat (3) tick(1, 2);
    tick(2, 2); tick(2, 0); tick(2, 0);
    chk("short_allred", {29'd0, fault_code}, 5);
    do_reset();
    tick(0, 2); tick(0, 2);
    repeat (3) tick(1, 2);
    tick(2, 2); tick(3, 0); tick(3, 0);
    chk("priority_illegal", {29'd0, fault_code}, 1);

    // Reset mid-flash
    do_reset();
    tick(0, 0);
    repeat (6) tick(2, 2);
    do_reset();

    // 256 legal cycles wrap the phase counter
    repeat (256) legal_cycle(1, MIN_YELLOW, MIN_ALLRED);
    chk("phase_wrap", {24'd0, phase_cnt}, 0);

    // Random walk over light codes with occasional garbage and clears
    do_reset();
    rh = 0;
    rc = 2;
    repeat (800) begin
      sel = $urandom_range(0, 99);
      if (sel >= 55 && sel < 92) begin
        if (rh != 2)      rh = (rh + 1) % 3;
        else if (rc != 2) rc = (rc + 1) % 3;
        else if ($urandom_range(0, 1) == 0) rh = 0;
        else rc = 0;
      end else if (sel >= 92) begin
        rh = $urandom_range(0, 3);
        rc = $urandom_range(0, 3);
      end
      tick(rh, rc, $urandom_range(0, 9) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
